game_st_cmd_sink: RTL and testbench

- Avalon-ST 8-bit sink that terminates the HPS-side streaming source (valid/ready/data/sop/eop) in FPGA fabric.
- Reassembles each packet into a command: the first byte is the opcode, the following bytes are payload.
- Holds the finished command for game logic behind a valid/ready handshake, with a registered random-access payload read port.
- Detects framing errors, counts them and discards the affected data.

---
 rtl/game_st_cmd_sink.sv | 204 ++++++++++++++++++++
 tb/tb_game_st_cmd_sink.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/game_st_cmd_sink.sv
`default_nettype none
// ============================================================================
// Module   : game_st_cmd_sink
// Purpose  : Avalon-ST 8-bit sink. It turns each HPS-side packet into a
//            command made of one opcode byte and a payload of up to MAX_LEN
//            bytes. The finished command is held for game logic behind a
//            valid/ready handshake. The payload is read back through a
//            registered random-access port. Framing errors are flagged,
//            counted and their data dropped.
// Ports    : clk_clk, reset_reset_n   - clock and async active-low reset
//            sti_*                    - Avalon-ST sink (ready latency 0)
//            cmd_valid/ready/opcode/len - held command and its handshake
//            rd_addr / rd_data        - payload read port, one-cycle latency
//            err_pulse/code/count     - framing error strobe, last code and
//                                       saturating counter
// Revision : 1.0 - initial release
// ============================================================================
module game_st_cmd_sink #(
    parameter  int MAX_LEN = 16,
    parameter  int ERR_W   = 16,
    localparam int LEN_W   = $clog2(MAX_LEN + 1)
) (
    input  logic             clk_clk,
    input  logic             reset_reset_n,
    output logic             sti_ready,
    input  logic             sti_valid,
    input  logic [7:0]       sti_data,
    input  logic             sti_startofpacket,
    input  logic             sti_endofpacket,
    output logic             cmd_valid,
    input  logic             cmd_ready,
    output logic [7:0]       cmd_opcode,
    output logic [LEN_W-1:0] cmd_len,
    input  logic [LEN_W-1:0] rd_addr,
    output logic [7:0]       rd_data,
    output logic             err_pulse,
    output logic [1:0]       err_code,
    output logic [ERR_W-1:0] err_count
);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_RECV = 2'd1;
    localparam logic [1:0] c_DROP = 2'd2;
    localparam logic [1:0] c_HOLD = 2'd3;

    localparam logic [1:0] c_ERR_ORPHAN   = 2'd1;
    localparam logic [1:0] c_ERR_RESTART  = 2'd2;
    localparam logic [1:0] c_ERR_OVERFLOW = 2'd3;

    localparam logic [LEN_W-1:0] c_MAX_LEN = LEN_W'(MAX_LEN);

    // The buffer is indexed with just enough bits to cover MAX_LEN entries.
    // Its depth is rounded up to a power of two so that every index value
    // is in range.
    localparam int c_IDX_W = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam int c_DEPTH = 2 ** c_IDX_W;

    logic [1:0]       state_q,     state_d;
    logic             ready_en_q,  ready_en_d;
    logic [7:0]       opcode_q,    opcode_d;
    logic [LEN_W-1:0] len_q,       len_d;
    logic [7:0]       rd_data_q,   rd_data_d;
    logic             err_pulse_q, err_pulse_d;
    logic [1:0]       err_code_q,  err_code_d;
    logic [ERR_W-1:0] err_count_q, err_count_d;

    logic [7:0]       buf_mem [c_DEPTH];

    logic             w_beat;
    logic             w_buf_we;
    logic             w_err_hit;
    logic [1:0]       w_err_code;

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            state_q     <= c_IDLE;
            ready_en_q  <= 1'b0;
            opcode_q    <= 8'h00;
            len_q       <= '0;
            rd_data_q   <= 8'h00;
            err_pulse_q <= 1'b0;
            err_code_q  <= 2'd0;
            err_count_q <= '0;
        end else begin
            state_q     <= state_d;
            ready_en_q  <= ready_en_d;
            opcode_q    <= opcode_d;
            len_q       <= len_d;
            rd_data_q   <= rd_data_d;
            err_pulse_q <= err_pulse_d;
            err_code_q  <= err_code_d;
            err_count_q <= err_count_d;
        end
    end

    // The payload store has no reset. Its contents only matter while a
    // command is held.
    always_ff @(posedge clk_clk) begin
        if (w_buf_we) begin
            buf_mem[len_q[c_IDX_W-1:0]] <= sti_data;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and datapath update
    // ------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        opcode_d   = opcode_q;
        len_d      = len_q;
        w_buf_we   = 1'b0;
        w_err_hit  = 1'b0;
        w_err_code = err_code_q;

        case (state_q)
            c_IDLE, c_DROP: begin
                if (w_beat) begin
                    if (sti_startofpacket) begin
                        opcode_d = sti_data;
                        len_d    = '0;
                        state_d  = sti_endofpacket ? c_HOLD : c_RECV;
                    end else if (state_q == c_IDLE) begin
                        w_err_hit  = 1'b1;
                        w_err_code = c_ERR_ORPHAN;
                    end else if (sti_endofpacket) begin
                        // Tail of an overflowed packet has now ended.
                        state_d = c_IDLE;
                    end
                end
            end
            c_RECV: begin
                if (w_beat) begin
                    if (sti_startofpacket) begin
                        // Drop the partial packet and start over on the new one.
                        w_err_hit  = 1'b1;
                        w_err_code = c_ERR_RESTART;
                        opcode_d   = sti_data;
                        len_d      = '0;
                        state_d    = sti_endofpacket ? c_HOLD : c_RECV;
                    end else if (len_q < c_MAX_LEN) begin
                        w_buf_we = 1'b1;
                        len_d    = len_q + LEN_W'(1);
                        if (sti_endofpacket) begin
                            state_d = c_HOLD;
                        end
                    end else begin
                        w_err_hit  = 1'b1;
                        w_err_code = c_ERR_OVERFLOW;
                        state_d    = sti_endofpacket ? c_IDLE : c_DROP;
                    end
                end
            end
            c_HOLD: begin
                if (cmd_ready) begin
                    state_d = c_IDLE;
                end
            end
            default: state_d = c_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Outputs decoded from registered state
    // ------------------------------------------------------------------
    always_comb begin
        sti_ready = ready_en_q && (state_q != c_HOLD);
        cmd_valid = (state_q == c_HOLD);
    end

    assign w_beat = sti_valid && sti_ready;

    // Ready comes up on the first edge after reset is released.
    assign ready_en_d = 1'b1;

    always_comb begin
        err_pulse_d = w_err_hit;
        err_code_d  = w_err_code;
        err_count_d = err_count_q;
        if (w_err_hit && (err_count_q != {ERR_W{1'b1}})) begin
            err_count_d = err_count_q + ERR_W'(1);
        end
    end

    // An address at or beyond the held length reads as zero. This also
    // keeps the buffer index inside the valid entries.
    always_comb begin
        rd_data_d = 8'h00;
        if (rd_addr < len_q) begin
            rd_data_d = buf_mem[rd_addr[c_IDX_W-1:0]];
        end
    end

    assign cmd_opcode = opcode_q;
    assign cmd_len    = len_q;
    assign rd_data    = rd_data_q;
    assign err_pulse  = err_pulse_q;
    assign err_code   = err_code_q;
    assign err_count  = err_count_q;

endmodule
`default_nettype wire

// File: tb/tb_game_st_cmd_sink.sv
`default_nettype none
// ============================================================================
// Module   : tb_game_st_cmd_sink
// Purpose  : Directed testbench for game_st_cmd_sink. It uses a vector table
//            for the basic packet flow, plus hand-written sequences for
//            back-pressure, overflow, orphan/restart errors, reset and
//            counter saturation.
// Revision : 1.0 - initial release
// ============================================================================
module tb_game_st_cmd_sink;

    localparam int MAX_LEN = 16;
    localparam int ERR_W   = 4;
    localparam int LEN_W   = $clog2(MAX_LEN + 1);

    logic             clk = 1'b0;
    logic             rst_n;
    logic             sti_ready;
    logic             sti_valid;
    logic [7:0]       sti_data;
    logic             sti_sop;
    logic             sti_eop;
    logic             cmd_valid;
    logic             cmd_ready;
    logic [7:0]       cmd_opcode;
    logic [LEN_W-1:0] cmd_len;
    logic [LEN_W-1:0] rd_addr;
    logic [7:0]       rd_data;
    logic             err_pulse;
    logic [1:0]       err_code;
    logic [ERR_W-1:0] err_count;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    game_st_cmd_sink #(
        .MAX_LEN(MAX_LEN),
        .ERR_W  (ERR_W)
    ) dut (
        .clk_clk          (clk),
        .reset_reset_n    (rst_n),
        .sti_ready        (sti_ready),
        .sti_valid        (sti_valid),
        .sti_data         (sti_data),
        .sti_startofpacket(sti_sop),
        .sti_endofpacket  (sti_eop),
        .cmd_valid        (cmd_valid),
        .cmd_ready        (cmd_ready),
        .cmd_opcode       (cmd_opcode),
        .cmd_len          (cmd_len),
        .rd_addr          (rd_addr),
        .rd_data          (rd_data),
        .err_pulse        (err_pulse),
        .err_code         (err_code),
        .err_count        (err_count)
    );

    typedef struct {
        logic             v;
        logic             s;
        logic             e;
        logic [7:0]       d;
        logic             cr;
        logic [LEN_W-1:0] ra;
        logic             x_rdy;
        logic             x_cv;
        logic [7:0]       x_op;
        logic [LEN_W-1:0] x_len;
        logic             chk_cmd;
        logic [7:0]       x_rd;
        logic             chk_rd;
    } vec_t;

    vec_t tbl [11];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one beat and hold it until the sink accepts it. The loop is
    // bounded so that a stuck sti_ready cannot hang the run.
    task automatic beat(input logic [7:0] d, input logic s, input logic e);
        int n;
        logic rdy;
        n = 0;
        sti_valid = 1'b1;
        sti_data  = d;
        sti_sop   = s;
        sti_eop   = e;
        do begin
            rdy = sti_ready;
            tick();
            n++;
        end while (!rdy && n < 50);
        sti_valid = 1'b0;
        sti_sop   = 1'b0;
        sti_eop   = 1'b0;
        chk("beat_accepted", 32'(rdy), 32'd1);
    endtask

    task automatic check_cmd(input logic [7:0] op, input logic [LEN_W-1:0] len);
        chk("cmd_valid", 32'(cmd_valid), 32'd1);
        chk("cmd_opcode", 32'(cmd_opcode), 32'(op));
        chk("cmd_len", 32'(cmd_len), 32'(len));
    endtask

    task automatic read(input logic [LEN_W-1:0] a, input logic [7:0] x);
        rd_addr = a;
        tick();
        chk("rd_data", 32'(rd_data), 32'(x));
    endtask

    task automatic consume();
        cmd_ready = 1'b1;
        tick();
        cmd_ready = 1'b0;
        chk("consume_cmd_valid", 32'(cmd_valid), 32'd0);
        chk("consume_sti_ready", 32'(sti_ready), 32'd1);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_sti_ready"}, 32'(sti_ready), 32'd0);
        chk({tag, "_cmd_valid"}, 32'(cmd_valid), 32'd0);
        chk({tag, "_opcode"}, 32'(cmd_opcode), 32'd0);
        chk({tag, "_len"}, 32'(cmd_len), 32'd0);
        chk({tag, "_rd_data"}, 32'(rd_data), 32'd0);
        chk({tag, "_err_pulse"}, 32'(err_pulse), 32'd0);
        chk({tag, "_err_code"}, 32'(err_code), 32'd0);
        chk({tag, "_err_count"}, 32'(err_count), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n     = 1'b0;
        sti_valid = 1'b0;
        sti_data  = 8'h00;
        sti_sop   = 1'b0;
        sti_eop   = 1'b0;
        cmd_ready = 1'b0;
        rd_addr   = '0;

        // Each row: the inputs for one edge, then the expected outputs after it.
        //          v     s     e     d      cr    ra     rdy   cv    op     len    chk   rd     chk
        tbl[0]  = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 5'd0,  1'b1, 1'b0, 8'h00, 5'd0, 1'b0, 8'h00, 1'b0};
        tbl[1]  = '{1'b1, 1'b1, 1'b0, 8'h21, 1'b0, 5'd0,  1'b1, 1'b0, 8'h00, 5'd0, 1'b0, 8'h00, 1'b0};
        tbl[2]  = '{1'b1, 1'b0, 1'b0, 8'hAA, 1'b0, 5'd0,  1'b1, 1'b0, 8'h00, 5'd0, 1'b0, 8'h00, 1'b0};
        tbl[3]  = '{1'b1, 1'b0, 1'b0, 8'hBB, 1'b0, 5'd0,  1'b1, 1'b0, 8'h00, 5'd0, 1'b0, 8'h00, 1'b0};
        tbl[4]  = '{1'b1, 1'b0, 1'b1, 8'hCC, 1'b0, 5'd0,  1'b0, 1'b1, 8'h21, 5'd3, 1'b1, 8'h00, 1'b0};
        tbl[5]  = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 5'd0,  1'b0, 1'b1, 8'h21, 5'd3, 1'b1, 8'hAA, 1'b1};
        tbl[6]  = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 5'd1,  1'b0, 1'b1, 8'h21, 5'd3, 1'b1, 8'hBB, 1'b1};
        tbl[7]  = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 5'd2,  1'b0, 1'b1, 8'h21, 5'd3, 1'b1, 8'hCC, 1'b1};
        tbl[8]  = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 5'd3,  1'b0, 1'b1, 8'h21, 5'd3, 1'b1, 8'h00, 1'b1};
        tbl[9]  = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 5'd16, 1'b0, 1'b1, 8'h21, 5'd3, 1'b1, 8'h00, 1'b1};
        tbl[10] = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 5'd0,  1'b1, 1'b0, 8'h00, 5'd0, 1'b0, 8'hAA, 1'b1};

        // Outputs while held in reset.
        #12;
        check_all_zero("reset");

        @(posedge clk);
        #1;
        rst_n = 1'b1;
        chk("ready_before_first_edge", 32'(sti_ready), 32'd0);

        // Basic packet, payload reads and release.
        for (int i = 0; i < 11; i++) begin
            sti_valid = tbl[i].v;
            sti_sop   = tbl[i].s;
            sti_eop   = tbl[i].e;
            sti_data  = tbl[i].d;
            cmd_ready = tbl[i].cr;
            rd_addr   = tbl[i].ra;
            tick();
            chk($sformatf("vec%0d_sti_ready", i), 32'(sti_ready), 32'(tbl[i].x_rdy));
            chk($sformatf("vec%0d_cmd_valid", i), 32'(cmd_valid), 32'(tbl[i].x_cv));
            chk($sformatf("vec%0d_err_pulse", i), 32'(err_pulse), 32'd0);
            chk($sformatf("vec%0d_err_count", i), 32'(err_count), 32'd0);
            if (tbl[i].chk_cmd) begin
                chk($sformatf("vec%0d_opcode", i), 32'(cmd_opcode), 32'(tbl[i].x_op));
                chk($sformatf("vec%0d_len", i), 32'(cmd_len), 32'(tbl[i].x_len));
            end
            if (tbl[i].chk_rd) begin
                chk($sformatf("vec%0d_rd_data", i), 32'(rd_data), 32'(tbl[i].x_rd));
            end
        end
        sti_valid = 1'b0;
        cmd_ready = 1'b0;
        rd_addr   = '0;

        // Zero-length command, then back-pressure on a second packet.
        beat(8'h05, 1'b1, 1'b1);
        check_cmd(8'h05, 5'd0);
        chk("hold_sti_ready", 32'(sti_ready), 32'd0);
        sti_valid = 1'b1;
        sti_data  = 8'h31;
        sti_sop   = 1'b1;
        sti_eop   = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("bp_sti_ready", 32'(sti_ready), 32'd0);
            chk("bp_cmd_valid", 32'(cmd_valid), 32'd1);
        end
        chk("bp_opcode_frozen", 32'(cmd_opcode), 32'h05);
        cmd_ready = 1'b1;
        tick();
        cmd_ready = 1'b0;
        chk("release_cmd_valid", 32'(cmd_valid), 32'd0);
        chk("release_sti_ready", 32'(sti_ready), 32'd1);
        tick();
        sti_valid = 1'b0;
        sti_sop   = 1'b0;
        chk("second_sop_taken_ready", 32'(sti_ready), 32'd1);
        chk("second_sop_taken_cv", 32'(cmd_valid), 32'd0);
        beat(8'h77, 1'b0, 1'b1);
        check_cmd(8'h31, 5'd1);
        read(5'd0, 8'h77);
        consume();

        // Overflow: opcode plus 20 payload bytes, where MAX_LEN is 16.
        beat(8'h40, 1'b1, 1'b0);
        for (int i = 0; i < 20; i++) begin
            beat(8'(i + 1), 1'b0, (i == 19));
            if (i == 16) begin
                chk("ovf_err_pulse", 32'(err_pulse), 32'd1);
            end
        end
        chk("ovf_cmd_valid", 32'(cmd_valid), 32'd0);
        chk("ovf_err_code", 32'(err_code), 32'd3);
        chk("ovf_err_count", 32'(err_count), 32'd1);
        beat(8'h41, 1'b1, 1'b0);
        beat(8'h99, 1'b0, 1'b1);
        check_cmd(8'h41, 5'd1);
        read(5'd0, 8'h99);
        consume();

        // Orphan beat in IDLE; the pulse must last exactly one cycle.
        beat(8'h3C, 1'b0, 1'b0);
        chk("orphan_pulse", 32'(err_pulse), 32'd1);
        chk("orphan_code", 32'(err_code), 32'd1);
        chk("orphan_count", 32'(err_count), 32'd2);
        tick();
        chk("orphan_pulse_width", 32'(err_pulse), 32'd0);

        // Restart: a new sop after 2 payload bytes.
        beat(8'h50, 1'b1, 1'b0);
        beat(8'h01, 1'b0, 1'b0);
        beat(8'h02, 1'b0, 1'b0);
        beat(8'h60, 1'b1, 1'b0);
        chk("restart_pulse", 32'(err_pulse), 32'd1);
        chk("restart_code", 32'(err_code), 32'd2);
        chk("restart_count", 32'(err_count), 32'd3);
        beat(8'h0A, 1'b0, 1'b0);
        beat(8'h0B, 1'b0, 1'b1);
        check_cmd(8'h60, 5'd2);
        read(5'd0, 8'h0A);
        read(5'd1, 8'h0B);
        read(5'd2, 8'h00);
        consume();

        // Reset while a command is held.
        beat(8'h70, 1'b1, 1'b1);
        chk("pre_reset_hold", 32'(cmd_valid), 32'd1);
        #3;
        rst_n = 1'b0;
        #1;
        check_all_zero("rst_hold");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        chk("rst_hold_ready_before_edge", 32'(sti_ready), 32'd0);
        tick();
        chk("rst_hold_ready_after_edge", 32'(sti_ready), 32'd1);

        // Reset part-way through a packet, then a clean packet.
        beat(8'h71, 1'b1, 1'b0);
        beat(8'h72, 1'b0, 1'b0);
        #3;
        rst_n = 1'b0;
        #1;
        check_all_zero("rst_recv");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick();
        chk("rst_recv_ready_after_edge", 32'(sti_ready), 32'd1);
        beat(8'h73, 1'b1, 1'b0);
        beat(8'h74, 1'b0, 1'b1);
        check_cmd(8'h73, 5'd1);
        read(5'd0, 8'h74);
        chk("post_reset_err_count", 32'(err_count), 32'd0);
        consume();

        // Saturation: 2^ERR_W + 3 orphan beats.
        for (int i = 0; i < (2 ** ERR_W) + 3; i++) begin
            beat(8'h55, 1'b0, 1'b0);
            if (i == 13) chk("sat_count_14", 32'(err_count), 32'd14);
            if (i == 14) chk("sat_count_15", 32'(err_count), 32'd15);
        end
        chk("sat_count_final", 32'(err_count), 32'd15);
        chk("sat_err_code", 32'(err_code), 32'd1);
        chk("sat_cmd_valid", 32'(cmd_valid), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
